// File: rtl/decodsimples_seq_pkg.sv
// rtl/decodsimples_seq_pkg.sv - shared state encoding and counter width for the sequential decoder
package decodsimples_seq_pkg;

   localparam int CNT_W = 8;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

endpackage

// File: rtl/decodsimples_seq_dec_onehot.sv
// rtl/decodsimples_seq_dec_onehot.sv - combinational N to 2**N one-hot decoder
module decodsimples_seq_dec_onehot #(
   parameter int N = 2
) (
   input  logic [N-1:0]    code,
   output logic [2**N-1:0] y
);

   always_comb begin
      y       = '0;
      y[code] = 1'b1;
   end

endmodule

// File: rtl/decodsimples_seq.sv
// rtl/decodsimples_seq.sv - sequential one-hot decoder with hold timer and one-entry pending buffer
module decodsimples_seq
   import decodsimples_seq_pkg::*;
#(
   parameter int N    = 2,
   parameter int HOLD = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N-1:0]    code,
   input  logic            en,
   output logic            ready,
   output logic [2**N-1:0] y,
   output logic            valid,
   output logic            done
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD - 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               pend_full;
   logic [N-1:0]       pend_code;
   logic [2**N-1:0]    code_oh;
   logic [2**N-1:0]    pend_oh;
   logic               accept;

   decodsimples_seq_dec_onehot #(.N(N)) u_dec_code (
      .code (code),
      .y    (code_oh)
   );

   decodsimples_seq_dec_onehot #(.N(N)) u_dec_pend (
      .code (pend_code),
      .y    (pend_oh)
   );

   assign ready  = ~pend_full;
   assign accept = en & ready;
   assign done   = (state == S_ACTIVE) && (cnt == '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         pend_full <= 1'b0;
         pend_code <= '0;
         y         <= '0;
         valid     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state <= S_ACTIVE;
                  y     <= code_oh;
                  valid <= 1'b1;
                  cnt   <= RELOAD;
               end
            end
            S_ACTIVE: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
                  if (accept) begin
                     pend_full <= 1'b1;
                     pend_code <= code;
                  end
               // Last cycle of a burst: a queued code wins over a live request
               end else if (pend_full) begin
                  y         <= pend_oh;
                  cnt       <= RELOAD;
                  pend_full <= 1'b0;
               end else if (accept) begin
                  y   <= code_oh;
                  cnt <= RELOAD;
               end else begin
                  state <= S_IDLE;
                  y     <= '0;
                  valid <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_decodsimples_seq.sv
// tb/tb_decodsimples_seq.sv - scoreboard bench for decodsimples_seq with HOLD=4 and HOLD=1 instances
module tb_decodsimples_seq;

   typedef struct packed {
      logic [3:0] y;
      logic       done;
   } exp_t;

   logic       clock;
   logic       reset;
   logic [1:0] code4, code1;
   logic       en4, en1;
   logic       ready4, ready1;
   logic [3:0] y4, y1;
   logic       valid4, valid1;
   logic       done4, done1;

   exp_t q4[$];
   exp_t q1[$];
   int   checks;
   int   errors;

   decodsimples_seq #(.N(2), .HOLD(4)) dut4 (
      .clock (clock),
      .reset (reset),
      .code  (code4),
      .en    (en4),
      .ready (ready4),
      .y     (y4),
      .valid (valid4),
      .done  (done4)
   );

   decodsimples_seq #(.N(2), .HOLD(1)) dut1 (
      .clock (clock),
      .reset (reset),
      .code  (code1),
      .en    (en1),
      .ready (ready1),
      .y     (y1),
      .valid (valid1),
      .done  (done1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic push_burst4(input logic [1:0] c);
      exp_t e;
      logic [3:0] oh;
      oh = 4'b0001 << c;
      for (int i = 0; i < 4; i++) begin
         e.y    = oh;
         e.done = (i == 3);
         q4.push_back(e);
      end
   endtask

   // Monitors: every cycle with valid high consumes one expected entry
   always @(negedge clock) begin
      exp_t e;
      if (!reset) begin
         if (valid4) begin
            if (q4.size() == 0) begin
               check("h4_unexpected_valid", {28'd0, y4}, 32'd0);
            end else begin
               e = q4.pop_front();
               check("h4_y_done", {27'd0, y4, done4}, {27'd0, e.y, e.done});
            end
         end else begin
            check("h4_idle_y_done", {27'd0, y4, done4}, 32'd0);
         end
         if (valid1) begin
            if (q1.size() == 0) begin
               check("h1_unexpected_valid", {28'd0, y1}, 32'd0);
            end else begin
               e = q1.pop_front();
               check("h1_y_done", {27'd0, y1, done1}, {27'd0, e.y, e.done});
            end
         end else begin
            check("h1_idle_y_done", {27'd0, y1, done1}, 32'd0);
         end
      end
   end

   initial begin
      exp_t e;
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      en4    = 1'b0;
      en1    = 1'b0;
      code4  = 2'b00;
      code1  = 2'b00;
      tick();
      check("reset_y", {28'd0, y4}, 32'd0);
      check("reset_valid_done_ready", {29'd0, valid4, done4, ready4}, 32'b001);
      check("reset_h1_ready", {31'd0, ready1}, 32'd1);
      reset = 1'b0;
      tick();

      // Single burst of code 10
      en4 = 1'b1; code4 = 2'b10; push_burst4(2'b10);
      tick();
      en4 = 1'b0;
      check("burst10_first_y", {28'd0, y4}, 32'h4);
      for (int i = 0; i < 4; i++) tick();
      check("burst10_end_valid", {31'd0, valid4}, 32'd0);
      check("burst10_q_empty", q4.size(), 32'd0);

      // All codes with idle gaps
      for (int c = 0; c < 4; c++) begin
         en4 = 1'b1; code4 = 2'(c); push_burst4(2'(c));
         tick();
         en4 = 1'b0;
         for (int i = 0; i < 6; i++) tick();
         check("allcodes_q_empty", q4.size(), 32'd0);
      end

      // en low with every code applied
      for (int i = 0; i < 10; i++) begin
         code4 = 2'(i);
         tick();
         check("en_low_valid_ready", {30'd0, valid4, ready4}, 32'b01);
      end

      // Back-to-back: 01 then 11 held, then a third code while ready=0
      en4 = 1'b1; code4 = 2'b01; push_burst4(2'b01); push_burst4(2'b11);
      tick();
      check("b2b_ready_n1", {31'd0, ready4}, 32'd1);
      check("b2b_valid_n1", {31'd0, valid4}, 32'd1);
      code4 = 2'b11;
      tick();
      check("b2b_ready_n2", {31'd0, ready4}, 32'd0);
      check("b2b_valid_n2", {31'd0, valid4}, 32'd1);
      code4 = 2'b00;
      for (int i = 3; i <= 4; i++) begin
         tick();
         check("b2b_ready_low", {31'd0, ready4}, 32'd0);
         check("b2b_valid_n34", {31'd0, valid4}, 32'd1);
      end
      tick();
      check("b2b_ready_after_handover", {31'd0, ready4}, 32'd1);
      check("b2b_y_after_handover", {28'd0, y4}, 32'h8);
      en4 = 1'b0;
      for (int i = 6; i <= 8; i++) begin
         tick();
         check("b2b_valid_second", {31'd0, valid4}, 32'd1);
      end
      tick();
      check("b2b_end_valid", {31'd0, valid4}, 32'd0);
      for (int i = 0; i < 4; i++) tick();
      check("b2b_q_empty", q4.size(), 32'd0);

      // Reset on 2nd cycle of a burst with pending full
      en4 = 1'b1; code4 = 2'b01;
      for (int i = 0; i < 2; i++) begin
         e.y = 4'b0010; e.done = 1'b0; q4.push_back(e);
      end
      tick();
      code4 = 2'b10;
      tick();
      en4 = 1'b0;
      check("rst_mid_pending_ready", {31'd0, ready4}, 32'd0);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_y", {28'd0, y4}, 32'd0);
      check("rst_mid_valid_ready", {30'd0, valid4, ready4}, 32'b01);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("rst_mid_q_empty", q4.size(), 32'd0);

      // HOLD=1: one new line per cycle
      for (int c = 0; c < 4; c++) begin
         e.y = 4'b0001 << c; e.done = 1'b1; q1.push_back(e);
      end
      en1 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         code1 = 2'(c);
         tick();
         check("h1_valid_each_cycle", {31'd0, valid1}, 32'd1);
      end
      en1 = 1'b0;
      tick();
      check("h1_end_valid", {31'd0, valid1}, 32'd0);
      tick();
      check("h1_q_empty", q1.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decodsimples_seq.md
Name: decodsimples_seq

Overview:
- Sequential decoder: the receiving end of the 2-bit priority code the simple priority encoder produces.
- Accepts an N-bit code under an enable/ready handshake and drives the matching one-hot line for HOLD clock cycles, then releases it.
- A one-entry pending buffer allows back-to-back codes with no idle gap.
- Sits downstream of the priority encoder and drives per-line actuators/LEDs in lab designs.

Parameters:
- N, 2, code width; output width is 2**N.
- HOLD, 4, cycles each decoded line stays high; legal range 1..255.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- code  input  N  code to decode.
- en  input  1  request; code is accepted on a rising edge when en=1 and ready=1.
- ready  output  1  1 when a code can be accepted; equals "pending buffer empty".
- y  output  2**N  registered one-hot output; all zeros when idle.
- valid  output  1  1 while y holds a decoded line.
- done  output  1  one-cycle pulse on the last cycle of each hold burst.

Behaviour:
- Reset (async, active-high): y=0, valid=0, done=0, counter=0, pending empty, state IDLE. ready=1 immediately.
- Reset asserted mid-burst: the line drops asynchronously and any pending code is discarded.
- State IDLE, accept (en & ready):
  - Next cycle: ACTIVE, y=1<<code, valid=1, counter=HOLD-1.
  - Latency from accepting edge to y: 1 cycle.
- State IDLE, en=0: y stays 0 and valid stays 0. This mirrors the encoder's output of 0 when its enable is low.
- State ACTIVE with counter>0:
  - counter decrements each cycle.
  - An accept stores code into the pending buffer, and ready drops the next cycle.
  - en is ignored while ready=0, and the code is not latched.
- State ACTIVE with counter==0 (the last cycle of the burst):
  - done=1 this cycle.
  - If pending is full: load y=1<<pending and counter=HOLD-1, clear pending, stay ACTIVE. The next burst starts with zero gap.
  - Else, if en=1 (ready is 1): bypass code directly into y, same as the pending-full case, with zero gap.
  - Else: go to IDLE with y=0 and valid=0.
- HOLD=1: every burst is a single cycle and done=valid. Back-to-back accepts produce a new line every cycle.
- done is combinational from (state==ACTIVE & counter==0); y and valid are registered.
- Invariant: at most one bit of y is high, and valid == |y.
- Counter width: 8 bits. HOLD is compared as HOLD-1, with no wrap-around.
- Same-code repeats are treated as new bursts; no merging.

Decomposition:
- Shared package/header (decod_defs.vh):
  - state encoding localparams S_IDLE=1'b0, S_ACTIVE=1'b1.
  - counter width constant CNT_W=8.
- Sub-module dec_onehot (purely combinational N to 2**N, used twice: for code and for the pending value). Everything else stays in the top module.

Test Plan (N=2, HOLD=4 unless noted):
- Reset, then code=2'b10 with en=1 for one cycle:
  - y=4'b0100 and valid=1 for exactly 4 cycles starting 1 cycle after the accept.
  - done=1 on the 4th cycle, then y=0.
- All codes 0..3 issued one at a time with idle gaps -> y equals 0001, 0010, 0100, 1000 respectively, each for 4 cycles.
- en=0 for 10 cycles with every code value applied -> y=0, valid=0, done=0 throughout, ready=1.
- Back-to-back: accept 01, then code=11 with en held high:
  - 11 goes to pending and ready=0 until the handover.
  - y goes 0010 for 4 cycles, then 1000 for 4 cycles, with no zero cycle between.
  - A third code presented while ready=0 is not latched.
- Reset asserted on the 2nd cycle of a burst with pending full -> y=0, valid=0 and ready=1 immediately; nothing is emitted after reset is released.
- HOLD=1 (separate elaboration): accept 00, 01, 10, 11 on consecutive edges -> y=0001, 0010, 0100, 1000 on consecutive cycles, with done=1 on each.
